// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - keypad-driven two-operand ALU operation sequencer
//
// Collects two hex keys into register-bank entries 0 and 1, runs the ALU for
// two cycles, writes the result to entry 2 and holds it until acknowledged.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start, op_in          begin an operation, ALU op latched on acceptance
//   key_valid, key_code   keypad encoder strobe and hex digit
//   abort                 synchronous return to IDLE, highest priority
//   alu_result, alu_zero  combinational ALU output and zero flag
//   result_ack            consumer acknowledge of result_valid
//   wr_en/wr_addr/wr_data register-bank write port (single-cycle pulses)
//   rd_addr_a/rd_addr_b   register-bank read addresses
//   alu_op                ALU operation select
//   result, result_zero   captured ALU result and zero flag
//   result_valid, busy    result held in DONE, sequencer not IDLE
//   timeout_err           key wait expired, cleared by the next start
//   state                 IDLE=0, LOAD_A=1, LOAD_B=2, EXEC=3, DONE=4
module calc_sequencer #(
  parameter int HOLDOFF = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op_in,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       abort,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  input  logic       result_ack,
  output logic       wr_en,
  output logic [1:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [1:0] rd_addr_a,
  output logic [1:0] rd_addr_b,
  output logic [1:0] alu_op,
  output logic [7:0] result,
  output logic       result_zero,
  output logic       result_valid,
  output logic       busy,
  output logic       timeout_err,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  // The wait counter only ever holds 0..TIMEOUT-1; the timeout fires as it
  // would step to TIMEOUT.
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [HW-1:0] holdoff_q, holdoff_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          exec_q, exec_d;
  logic          wr_en_q, wr_en_d;
  logic [1:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [1:0]    rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic [1:0]    alu_op_q, alu_op_d;
  logic [7:0]    result_q, result_d;
  logic          zero_q, zero_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          terr_q, terr_d;
  logic          key_ok;

  // A key directly after a write is refused even with HOLDOFF=0 so that
  // wr_en can never be high on two consecutive cycles.
  assign key_ok = key_valid && (holdoff_q == '0) && !wr_en_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    holdoff_d = (holdoff_q != '0) ? holdoff_q - HW'(1) : '0;
    wait_d    = wait_q;
    exec_d    = exec_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_a_d    = rd_a_q;
    rd_b_d    = rd_b_q;
    alu_op_d  = alu_op_q;
    result_d  = result_q;
    zero_d    = zero_q;
    valid_d   = valid_q;
    terr_d    = terr_q;

    if (abort) begin
      state_d   = S_IDLE;
      valid_d   = 1'b0;
      holdoff_d = '0;
      wait_d    = '0;
      exec_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_d    = op_in;
            terr_d  = 1'b0;
            wait_d  = '0;
            state_d = S_LOAD_A;
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (key_ok) begin
            wr_en_d   = 1'b1;
            wr_addr_d = (state_q == S_LOAD_A) ? 2'd0 : 2'd1;
            wr_data_d = {4'b0, key_code};
            holdoff_d = HOLD_LOAD;
            wait_d    = '0;
            if (state_q == S_LOAD_A) begin
              state_d = S_LOAD_B;
            end else begin
              // Read addresses and op are set up on entry so the ALU is
              // driven for both EXEC cycles.
              state_d  = S_EXEC;
              exec_d   = 1'b0;
              rd_a_d   = 2'd0;
              rd_b_d   = 2'd1;
              alu_op_d = op_q;
            end
          end else if (wait_q == WAIT_LAST) begin
            state_d = S_IDLE;
            terr_d  = 1'b1;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end
        S_EXEC: begin
          // The reg1 write lands during the first cycle; the ALU output is
          // only trusted at the end of the second.
          if (!exec_q) begin
            exec_d = 1'b1;
          end else begin
            exec_d    = 1'b0;
            result_d  = alu_result;
            zero_d    = alu_zero;
            wr_en_d   = 1'b1;
            wr_addr_d = 2'd2;
            wr_data_d = alu_result;
            valid_d   = 1'b1;
            state_d   = S_DONE;
          end
        end
        S_DONE: begin
          if (result_ack) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      holdoff_q <= '0;
      wait_q    <= '0;
      exec_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_a_q    <= '0;
      rd_b_q    <= '0;
      alu_op_q  <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      holdoff_q <= holdoff_d;
      wait_q    <= wait_d;
      exec_q    <= exec_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_a_q    <= rd_a_d;
      rd_b_q    <= rd_b_d;
      alu_op_q  <= alu_op_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      terr_q    <= terr_d;
    end
  end

  assign state        = state_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign rd_addr_a    = rd_a_q;
  assign rd_addr_b    = rd_b_q;
  assign alu_op       = alu_op_q;
  assign result       = result_q;
  assign result_zero  = zero_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;
  assign timeout_err  = terr_q;

endmodule
